// File: rtl/qa_drv_prim_filter_pkg.sv
// Shared types for the counting filter: drain FSM state and saturation helpers.
package qa_drv_prim_filter_pkg;

  // Drain sequencing: wait for every bucket to empty, then pulse done once.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } t_filter_drain_state;

  // Largest value a bucket counter of the given width can hold.
  function automatic int unsigned bucket_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/qa_drv_prim_filter_bucket_delta.sv
// Per-bucket increment/decrement counts: how many enabled insert ports and
// how many enabled remove ports address this bucket in the current cycle.
module qa_drv_prim_filter_bucket_delta
  import qa_drv_prim_filter_pkg::*;
#(
  parameter int N_BUCKETS        = 16,
  parameter int N_INSERT_CLIENTS = 2,
  parameter int N_REMOVE_CLIENTS = 2,
  parameter int BUCKET_IDX       = 0,
  parameter int IDX_W            = $clog2(N_BUCKETS),
  parameter int UP_W             = $clog2(N_INSERT_CLIENTS + 1),
  parameter int DN_W             = $clog2(N_REMOVE_CLIENTS + 1)
) (
  input  logic [N_INSERT_CLIENTS-1:0][IDX_W-1:0] insert,
  input  logic [N_INSERT_CLIENTS-1:0]            insert_en,
  input  logic [N_REMOVE_CLIENTS-1:0][IDX_W-1:0] remove,
  input  logic [N_REMOVE_CLIENTS-1:0]            remove_en,
  output logic [UP_W-1:0]                        up,
  output logic [DN_W-1:0]                        down
);

  localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(BUCKET_IDX);

  // Count matching enabled insert ports.
  always_comb begin
    up = '0;
    for (int i = 0; i < N_INSERT_CLIENTS; i++)
      if (insert_en[i] && (insert[i] == MY_IDX)) up = up + UP_W'(1);
  end

  // Count matching enabled remove ports.
  always_comb begin
    down = '0;
    for (int i = 0; i < N_REMOVE_CLIENTS; i++)
      if (remove_en[i] && (remove[i] == MY_IDX)) down = down + DN_W'(1);
  end

endmodule

// File: rtl/qa_drv_prim_filter_counting_sat.sv
// Counting filter with saturating per-bucket counters, zero-latency test
// ports, occupancy count and a drain sequencer that blocks inserts until
// every bucket has emptied.
// Optional: define QA_FILTER_COUNTING_ERR_CHECK_EN to enable sticky
// overflow/underflow flags; otherwise both flags are tied to 0.
module qa_drv_prim_filter_counting_sat
  import qa_drv_prim_filter_pkg::*;
#(
  parameter int N_BUCKETS        = 16,
  parameter int BITS_PER_BUCKET  = 4,
  parameter int N_TEST_CLIENTS   = 1,
  parameter int N_INSERT_CLIENTS = 2,
  parameter int N_REMOVE_CLIENTS = 2,
  parameter int NOTFULL_HEADROOM = N_INSERT_CLIENTS
) (
  input  logic                                                 clk,
  input  logic                                                 resetb,
  input  logic [N_TEST_CLIENTS-1:0][$clog2(N_BUCKETS)-1:0]     test_req,
  output logic [N_TEST_CLIENTS-1:0]                            test_notFull,
  output logic [N_TEST_CLIENTS-1:0]                            test_isZero,
  input  logic [N_INSERT_CLIENTS-1:0][$clog2(N_BUCKETS)-1:0]   insert,
  input  logic [N_INSERT_CLIENTS-1:0]                          insert_en,
  input  logic [N_REMOVE_CLIENTS-1:0][$clog2(N_BUCKETS)-1:0]   remove,
  input  logic [N_REMOVE_CLIENTS-1:0]                          remove_en,
  output logic                                                 insert_rdy,
  input  logic                                                 drain_req,
  output logic                                                 drain_done,
  output logic [$clog2(N_BUCKETS+1)-1:0]                       occupancy,
  output logic                                                 err_overflow,
  output logic                                                 err_underflow
);

  localparam int IDX_W = $clog2(N_BUCKETS);
  localparam int OCC_W = $clog2(N_BUCKETS + 1);
  localparam int BPB   = BITS_PER_BUCKET;
  localparam int UP_W  = $clog2(N_INSERT_CLIENTS + 1);
  localparam int DN_W  = $clog2(N_REMOVE_CLIENTS + 1);
  // Signed working width: holds cur+up (positive) and cur-down (negative)
  // without wrapping.
  localparam int SUM_W = BPB + UP_W + DN_W + 1;
  localparam int MAX_I = int'(bucket_max(BPB));
  // notFull threshold; may be negative for very large headroom, in which
  // case the compare below is simply never true.
  localparam int NF_LIMIT = MAX_I - NOTFULL_HEADROOM;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_I);

  logic [N_BUCKETS-1:0][BPB-1:0]  cnt_q;
  logic [N_BUCKETS-1:0][BPB-1:0]  cnt_d;
  logic [N_BUCKETS-1:0][UP_W-1:0] up;
  logic [N_BUCKETS-1:0][DN_W-1:0] down;
  logic [N_BUCKETS-1:0]           clamp_hi;
  logic [N_BUCKETS-1:0]           clamp_lo;
  logic [N_INSERT_CLIENTS-1:0]    ins_en_g;
  logic                           all_zero;
  t_filter_drain_state            state;

  // Inserts only land while the sequencer is idle; removes always proceed.
  assign ins_en_g = insert_en & {N_INSERT_CLIENTS{insert_rdy}};

  genvar gb;
  generate
    for (gb = 0; gb < N_BUCKETS; gb++) begin : g_bkt
      qa_drv_prim_filter_bucket_delta #(
        .N_BUCKETS        (N_BUCKETS),
        .N_INSERT_CLIENTS (N_INSERT_CLIENTS),
        .N_REMOVE_CLIENTS (N_REMOVE_CLIENTS),
        .BUCKET_IDX       (gb),
        .IDX_W            (IDX_W),
        .UP_W             (UP_W),
        .DN_W             (DN_W)
      ) u_delta (
        .insert    (insert),
        .insert_en (ins_en_g),
        .remove    (remove),
        .remove_en (remove_en),
        .up        (up[gb]),
        .down      (down[gb])
      );
    end
  endgenerate

  // Net each bucket's inserts against its removes, then clamp to [0, MAX].
  always_comb begin
    logic signed [SUM_W-1:0] sum;
    cnt_d    = cnt_q;
    clamp_hi = '0;
    clamp_lo = '0;
    for (int b = 0; b < N_BUCKETS; b++) begin
      sum = $signed({{(SUM_W-BPB){1'b0}}, cnt_q[b]})
          + $signed({{(SUM_W-UP_W){1'b0}}, up[b]})
          - $signed({{(SUM_W-DN_W){1'b0}}, down[b]});
      if (sum < 0) begin
        clamp_lo[b] = 1'b1;
        cnt_d[b]    = '0;
      end else if (sum > MAX_S) begin
        clamp_hi[b] = 1'b1;
        cnt_d[b]    = '1;
      end else begin
        cnt_d[b]    = sum[BPB-1:0];
      end
    end
  end

  // Bucket counter storage.
  always_ff @(posedge clk) begin
    if (!resetb) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Test ports look straight at the registered counters.
  always_comb begin
    test_notFull = '0;
    test_isZero  = '0;
    for (int t = 0; t < N_TEST_CLIENTS; t++) begin
      test_notFull[t] = (int'(cnt_q[test_req[t]]) <= NF_LIMIT);
      test_isZero[t]  = (cnt_q[test_req[t]] == '0);
    end
  end

  // Popcount of non-empty buckets.
  always_comb begin
    occupancy = '0;
    for (int b = 0; b < N_BUCKETS; b++)
      occupancy = occupancy + OCC_W'(cnt_q[b] != '0);
  end

  assign all_zero = (cnt_q == '0);

  // Drain sequencer; drain_done and insert_rdy are registered alongside state.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state      <= IDLE;
      drain_done <= 1'b0;
      insert_rdy <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          drain_done <= 1'b0;
          if (drain_req) begin
            state      <= DRAIN;
            insert_rdy <= 1'b0;
          end
        end
        DRAIN: begin
          if (all_zero) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          drain_done <= 1'b0;
          insert_rdy <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          drain_done <= 1'b0;
          insert_rdy <= 1'b1;
        end
      endcase
    end
  end

`ifdef QA_FILTER_COUNTING_ERR_CHECK_EN
  // Sticky saturation flags: any bucket clamping sets them until reset.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (|clamp_hi) err_overflow  <= 1'b1;
      if (|clamp_lo) err_underflow <= 1'b1;
    end
  end
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_qa_drv_prim_filter_counting_sat.sv
// Directed bench for the counting filter: saturation, netting, notFull
// threshold, drain sequencing and reset abort.
module tb_qa_drv_prim_filter_counting_sat;

  localparam int NB   = 16;
  localparam int IW   = 4;
  localparam int NT   = 2;
  localparam int NI   = 2;
  localparam int NR   = 2;

`ifdef QA_FILTER_COUNTING_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                  clk;
  logic                  resetb;
  logic [NT-1:0][IW-1:0] test_req;
  logic [NT-1:0]         test_notFull;
  logic [NT-1:0]         test_isZero;
  logic [NI-1:0][IW-1:0] insert;
  logic [NI-1:0]         insert_en;
  logic [NR-1:0][IW-1:0] remove;
  logic [NR-1:0]         remove_en;
  logic                  insert_rdy;
  logic                  drain_req;
  logic                  drain_done;
  logic [4:0]            occupancy;
  logic                  err_overflow;
  logic                  err_underflow;

  int tests = 0;
  int fails = 0;

  qa_drv_prim_filter_counting_sat #(
    .N_BUCKETS        (NB),
    .BITS_PER_BUCKET  (4),
    .N_TEST_CLIENTS   (NT),
    .N_INSERT_CLIENTS (NI),
    .N_REMOVE_CLIENTS (NR),
    .NOTFULL_HEADROOM (2)
  ) dut (
    .clk           (clk),
    .resetb        (resetb),
    .test_req      (test_req),
    .test_notFull  (test_notFull),
    .test_isZero   (test_isZero),
    .insert        (insert),
    .insert_en     (insert_en),
    .remove        (remove),
    .remove_en     (remove_en),
    .insert_rdy    (insert_rdy),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .occupancy     (occupancy),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    resetb = 1'b0; drain_req = 1'b0;
    test_req = '0; insert = '0; insert_en = '0; remove = '0; remove_en = '0;
    tick(); tick();
    test_req[0] = 4'd0; test_req[1] = 4'd9; #1;
    check("rst_isZero",   32'(test_isZero),   32'd3);
    check("rst_notFull",  32'(test_notFull),  32'd3);
    check("rst_occ",      32'(occupancy),     32'd0);
    check("rst_rdy",      32'(insert_rdy),    32'd1);
    check("rst_done",     32'(drain_done),    32'd0);
    check("rst_ovf",      32'(err_overflow),  32'd0);
    check("rst_udf",      32'(err_underflow), 32'd0);
    resetb = 1'b1; tick();

    // Both insert ports hit bucket 3 in one cycle.
    insert[0] = 4'd3; insert[1] = 4'd3; insert_en = 2'b11; tick(); insert_en = '0;
    test_req[0] = 4'd3; test_req[1] = 4'd4; #1;
    check("b3_cnt",    32'(dut.cnt_q[3]), 32'd2);
    check("b3_occ",    32'(occupancy),    32'd1);
    check("b3_isZero", 32'(test_isZero),  32'd2);

    // Fill bucket 5 to 15, then push past the top.
    insert[0] = 4'd5; insert[1] = 4'd5; insert_en = 2'b11;
    repeat (7) tick();
    insert_en = 2'b01; tick(); insert_en = '0;
    test_req[0] = 4'd5; #1;
    check("b5_full",      32'(dut.cnt_q[5]),   32'd15);
    check("b5_ovf_pre",   32'(err_overflow),   32'd0);
    check("b5_notFull",   32'(test_notFull[0]), 32'd0);
    insert_en = 2'b11; tick(); insert_en = '0;
    check("b5_sat",       32'(dut.cnt_q[5]),   32'd15);
    check("b5_ovf",       32'(err_overflow),   32'(EXP_ERR));
    tick();
    check("b5_ovf_stick", 32'(err_overflow),   32'(EXP_ERR));
    check("occ2",         32'(occupancy),      32'd2);

    // Remove from an empty bucket.
    remove[0] = 4'd7; remove_en = 2'b01; tick(); remove_en = '0;
    test_req[1] = 4'd7; #1;
    check("b7_cnt",    32'(dut.cnt_q[7]),   32'd0);
    check("b7_udf",    32'(err_underflow),  32'(EXP_ERR));
    check("b7_isZero", 32'(test_isZero[1]), 32'd1);
    check("b7_occ",    32'(occupancy),      32'd2);

    // notFull threshold on bucket 2: 13 is the last value with room for 2.
    insert[0] = 4'd2; insert[1] = 4'd2; insert_en = 2'b11;
    repeat (6) tick();
    insert_en = 2'b01; tick(); insert_en = '0;
    test_req[1] = 4'd2; #1;
    check("b2_13_cnt", 32'(dut.cnt_q[2]),    32'd13);
    check("b2_13_nf",  32'(test_notFull[1]), 32'd1);
    insert_en = 2'b01; tick(); insert_en = '0;
    check("b2_14_nf",  32'(test_notFull[1]), 32'd0);
    // Simultaneous insert and remove on bucket 5 at 15 nets to no change.
    insert[0] = 4'd5; insert_en = 2'b01; remove[0] = 4'd5; remove_en = 2'b01;
    tick(); insert_en = '0; remove_en = '0;
    check("b5_net",    32'(dut.cnt_q[5]),    32'd15);
    check("occ3",      32'(occupancy),       32'd3);

    // Reset clears counters and sticky flags.
    resetb = 1'b0; tick();
    check("rst2_occ", 32'(occupancy),     32'd0);
    check("rst2_ovf", 32'(err_overflow),  32'd0);
    check("rst2_udf", 32'(err_underflow), 32'd0);
    resetb = 1'b1; tick();

    // Drain with nothing stored completes in its first DRAIN cycle.
    drain_req = 1'b1; tick(); drain_req = 1'b0;
    check("dr0_rdy",   32'(insert_rdy), 32'd0);
    check("dr0_done0", 32'(drain_done), 32'd0);
    tick();
    check("dr0_done1", 32'(drain_done), 32'd1);
    tick();
    check("dr0_done2", 32'(drain_done), 32'd0);
    check("dr0_rdy2",  32'(insert_rdy), 32'd1);

    // Bucket 1 at 2, drain; inserts while draining are dropped.
    insert[0] = 4'd1; insert[1] = 4'd1; insert_en = 2'b11; tick(); insert_en = '0;
    drain_req = 1'b1; tick(); drain_req = 1'b0;
    insert_en = 2'b11; tick(); insert_en = '0;
    check("dr1_ign",   32'(dut.cnt_q[1]), 32'd2);
    check("dr1_rdy",   32'(insert_rdy),   32'd0);
    remove[0] = 4'd1; remove_en = 2'b01; drain_req = 1'b1; tick(); drain_req = 1'b0;
    check("dr1_cnt1",  32'(dut.cnt_q[1]), 32'd1);
    tick(); remove_en = '0;
    check("dr1_cnt0",  32'(dut.cnt_q[1]), 32'd0);
    check("dr1_nodone",32'(drain_done),   32'd0);
    tick();
    check("dr1_done",  32'(drain_done),   32'd1);
    tick();
    check("dr1_done0", 32'(drain_done),   32'd0);
    check("dr1_rdy1",  32'(insert_rdy),   32'd1);

    // Reset in the middle of a drain aborts it.
    insert[0] = 4'd4; insert_en = 2'b01; tick(); insert_en = '0;
    drain_req = 1'b1; tick(); drain_req = 1'b0;
    tick();
    check("ab_rdy0",  32'(insert_rdy), 32'd0);
    resetb = 1'b0; tick();
    check("ab_done",  32'(drain_done), 32'd0);
    check("ab_rdy",   32'(insert_rdy), 32'd1);
    check("ab_occ",   32'(occupancy),  32'd0);
    resetb = 1'b1; tick();
    check("ab_done1", 32'(drain_done), 32'd0);
    tick();
    check("ab_done2", 32'(drain_done), 32'd0);
    check("ab_rdy2",  32'(insert_rdy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qa_drv_prim_filter_counting_sat.md
QA_DRV_PRIM_FILTER_COUNTING_SAT -- requirements
Module: qa_drv_prim_filter_counting_sat

Interface
REQ-001 SHALL have parameter N_BUCKETS, default 16, number of buckets.
REQ-002 SHALL have parameter BITS_PER_BUCKET, default 4, counter width per bucket.
REQ-003 SHALL have parameter N_TEST_CLIENTS, default 1, number of test ports.
REQ-004 SHALL have parameter N_INSERT_CLIENTS, default 2, number of insert ports.
REQ-005 SHALL have parameter N_REMOVE_CLIENTS, default 2, number of remove ports.
REQ-006 SHALL have parameter NOTFULL_HEADROOM, default N_INSERT_CLIENTS, number of free counts required for notFull.
REQ-007 SHALL have ports, in order:
- clk  in  1  clock.
- resetb  in  1  reset, synchronous, active-low.
- test_req  in  N_TEST_CLIENTS x clog2(N_BUCKETS)  bucket index per test port.
- test_notFull  out  N_TEST_CLIENTS  bucket can absorb NOTFULL_HEADROOM inserts.
- test_isZero  out  N_TEST_CLIENTS  bucket count is 0.
- insert / insert_en  in  N_INSERT_CLIENTS x clog2(N_BUCKETS) / N_INSERT_CLIENTS  increment requests.
- remove / remove_en  in  N_REMOVE_CLIENTS x clog2(N_BUCKETS) / N_REMOVE_CLIENTS  decrement requests.
- insert_rdy  out  1  inserts are accepted.
- drain_req  in  1  start-drain pulse.
- drain_done  out  1  one-cycle pulse when drain completes.
- occupancy  out  clog2(N_BUCKETS+1)  number of non-zero buckets.
- err_overflow / err_underflow  out  1 each  sticky saturation error flags.

Function
REQ-008 Test outputs SHALL be combinational from the current registered counters, with zero latency.
REQ-009 test_notFull SHALL be 1 iff counter <= 2^BITS_PER_BUCKET-1-NOTFULL_HEADROOM; the comparison is exact, not a high-bit approximation.
REQ-010 Per bucket, up SHALL be the count of enabled insert ports matching the bucket, and down the count of enabled remove ports matching it.
REQ-011 Per bucket, the next counter SHALL be clamp(cur+up-down, 0, MAX), evaluated in a width wide enough that the intermediate never wraps.
REQ-012 An insert and a remove to the same bucket in the same cycle SHALL net; no saturation occurs unless the net result is out of range.
REQ-013 occupancy SHALL be the combinational popcount of (counter != 0) over the current registered counters.
REQ-014 The drain FSM SHALL have states IDLE, DRAIN and DONE.
REQ-015 In IDLE, drain_req=1 SHALL move the FSM to DRAIN; drain_req is ignored in every other state.
REQ-016 In DRAIN, the FSM SHALL move to DONE in the first cycle in which all registered counters are 0, including the first DRAIN cycle.
REQ-017 DONE SHALL last one cycle and then return to IDLE; drain_done=1 only in DONE.
REQ-018 insert_rdy SHALL be 1 only in IDLE; while insert_rdy=0, insert_en is ignored and removes proceed.

Reset
REQ-019 While resetb=0, all counters SHALL be 0, the FSM SHALL be in IDLE, and err flags SHALL be 0.
REQ-020 Outputs after reset SHALL be: test_isZero all 1, test_notFull all 1, occupancy 0, insert_rdy 1, drain_done 0.
REQ-021 Reset during DRAIN or DONE SHALL abort the drain with no drain_done pulse.

Configuration
REQ-022 With QA_FILTER_COUNTING_ERR_CHECK_EN defined, err_overflow SHALL set when any bucket clamps high, and err_underflow SHALL set when any bucket clamps low.
REQ-023 Both err flags SHALL be sticky until reset.
REQ-024 Without QA_FILTER_COUNTING_ERR_CHECK_EN, both err flags SHALL be constant 0; clamping is unchanged.

Structure
REQ-025 Package qa_drv_prim_filter_pkg SHALL hold the drain-state enum t_filter_drain_state.
REQ-026 Sub-module qa_drv_prim_filter_bucket_delta SHALL compute up/down for one bucket from the port vectors; it is instantiated N_BUCKETS times.

Verification
REQ-027 Reset, then insert bucket 3 on both ports for one cycle -> counter[3]=2, occupancy=1, test_isZero(3)=0.
REQ-028 Increment bucket 5 to 15, then insert it on 2 ports -> counter stays 15; err_overflow=1 and stays 1 (macro on); err_overflow=0 (macro off).
REQ-029 Remove from bucket 7 at 0 -> counter stays 0; err_underflow=1 (macro on).
REQ-030 Bucket 2 at 13 with headroom 2 -> notFull=1; at 14 -> notFull=0.
REQ-031 Bucket 1 at 2, pulse drain_req while inserting bucket 1 -> insert ignored; remove bucket 1 twice -> drain_done pulse next cycle, then insert_rdy=1.
REQ-032 Assert reset during DRAIN -> FSM returns to IDLE, no drain_done pulse, and all counters are 0.
